// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory responder: RV32I load/store funct3
// codes, the responder FSM encoding and byte-lane/extension helpers.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] LANE_B = 4'b0001;
    localparam logic [3:0] LANE_H = 4'b0011;
    localparam logic [3:0] LANE_W = 4'b1111;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Only the low two funct3 bits carry the access size for both loads and stores.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
        return ((f3[1:0] == 2'b01) && lane[0]) || ((f3[1:0] == 2'b10) && (lane != 2'b00));
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] lane);
        case (f3)
            F3_B:    return LANE_B << lane;
            F3_H:    return LANE_H << lane;
            F3_W:    return LANE_W;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicating the store data puts it on every lane the mask can select.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wdata);
        case (f3)
            F3_B:    return {4{wdata[7:0]}};
            F3_H:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    return {{24{b[7]}}, b};
            F3_BU:   return {24'h000000, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_HU:   return {16'h0000, h};
            F3_W:    return word;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between a load/store initiator and the
// data memory responder.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with per-byte write enables and a
// registered read port; contents are never reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    // One byte-wide array per lane keeps each lane an independent RAM column.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] r_mem [DEPTH_WORDS];
        logic [7:0] r_rdata;

        always_ff @(posedge clk) begin
            if (i_en) begin
                if (i_be[gi]) r_mem[i_addr] <= i_wdata[gi*8 +: 8];
                r_rdata <= r_mem[i_addr];
            end
        end

        assign o_rdata[gi*8 +: 8] = r_rdata;
    end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency RV32I data memory responder: accepts one load/store at a time,
// performs it LATENCY edges after acceptance and holds the response until taken.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input logic                 clk,
    input logic                 reset_n,
    data_mem_responder_if.slave bus
);

    localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_resp_valid;
    logic        r_resp_err;

    logic          w_in_range;
    logic          w_err;
    logic          w_access;
    logic          w_ram_en;
    logic [3:0]    w_ram_be;
    logic [AW-1:0] w_ram_addr;
    logic [31:0]   w_ram_wdata;
    logic [31:0]   w_ram_rdata;

    assign w_in_range  = {2'b00, r_addr[31:2]} < 32'(DEPTH_WORDS);
    assign w_err       = !funct3_legal(r_we, r_funct3) || misaligned(r_funct3, r_addr[1:0]) || !w_in_range;
    assign w_access    = (r_state == WAIT) && (r_cnt == 4'd0);
    // A rejected request never touches the RAM, so neither writes nor the read register change.
    assign w_ram_en    = w_access && !w_err;
    assign w_ram_be    = r_we ? store_mask(r_funct3, r_addr[1:0]) : 4'b0000;
    assign w_ram_addr  = r_addr[AW+1:2];
    assign w_ram_wdata = store_data(r_funct3, r_wdata);

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk    (clk),
        .i_en   (w_ram_en),
        .i_be   (w_ram_be),
        .i_addr (w_ram_addr),
        .i_wdata(w_ram_wdata),
        .o_rdata(w_ram_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= 32'h0000_0000;
            r_wdata      <= 32'h0000_0000;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_we     <= bus.req_we;
                        r_funct3 <= bus.req_funct3;
                        r_addr   <= bus.req_addr;
                        r_wdata  <= bus.req_wdata;
                        r_cnt    <= CNT_LOAD;
                        r_state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= w_err;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        r_state      <= IDLE;
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // RAM output only moves on an access edge, so load data stays stable through RESP.
    assign bus.req_ready  = (r_state == IDLE) && reset_n;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = (r_resp_valid && !r_resp_err && !r_we)
                          ? load_extend(r_funct3, r_addr[1:0], w_ram_rdata) : 32'h0000_0000;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words stored.
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request accept to resp_valid; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 1 bit, initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit, responder can accept a request.
REQ-007 SHALL have port req_we, input, 1 bit, 1 = store, 0 = load.
REQ-008 SHALL have port req_funct3, input, 3 bits, RV32I load/store funct3 (access size and sign).
REQ-009 SHALL have port req_addr, input, 32 bits, byte address.
REQ-010 SHALL have port req_wdata, input, 32 bits, store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1 bit, response available.
REQ-012 SHALL have port resp_ready, input, 1 bit, initiator accepts the response.
REQ-013 SHALL have port resp_rdata, output, 32 bits, extended load data; 0 for stores and errors.
REQ-014 SHALL have port resp_err, output, 1 bit, request was rejected (misaligned, out of range or illegal funct3).

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE with reset_n high.
REQ-016 SHALL accept a request on a rising edge with req_valid && req_ready, latch we/funct3/addr/wdata, load counter with LATENCY-1, and enter WAIT.
REQ-017 SHALL, in WAIT, decrement the counter each cycle; when counter = 0, perform the access and enter RESP on that edge.
REQ-018 SHALL assert resp_valid exactly LATENCY edges after the accepting edge, holding resp_rdata/resp_err stable until resp_ready.
REQ-019 SHALL leave RESP for IDLE on the edge where resp_valid && resp_ready; the next request is accepted no earlier than the following edge.
REQ-020 SHALL ignore req_valid outside IDLE; request inputs need not be held after acceptance.
REQ-021 SHALL support loads LB 000, LH 001, LW 010, LBU 100, LHU 101, with LB/LH sign-extended and LBU/LHU zero-extended.
REQ-022 SHALL support stores SB 000, SH 001, SW 010, writing only the addressed little-endian byte lanes (lane = addr[1:0]).
REQ-023 SHALL flag resp_err for: halfword with addr[0] = 1; word with addr[1:0] != 0; addr[31:2] >= DEPTH_WORDS; load funct3 011/110/111; store funct3 other than 000/001/010.
REQ-024 SHALL, on an error, suppress all memory writes and return resp_rdata = 0.
REQ-025 SHALL leave memory contents unchanged by loads.

Reset
REQ-026 SHALL, while reset_n = 0, force state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0, req_ready 0.
REQ-027 SHALL discard a request in WAIT when reset asserts, with no write performed; a write already done in WAIT stays committed.
REQ-028 SHALL NOT reset memory array contents.

Structure
REQ-029 SHALL place funct3 constants, the FSM state encoding and lane/extension helper constants in shared package dmem_pkg.
REQ-030 SHALL instantiate sub-module dmem_array: a single-port synchronous word RAM, DEPTH_WORDS x 32, with a 4-bit byte-write enable.

Verification
REQ-031 SHALL cover this scenario: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rdata 0xDEADBEEF, err 0, resp_valid exactly 2 edges after accept.
REQ-032 SHALL cover this scenario: SB 0x13 data 0x80, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80ADBEEF.
REQ-033 SHALL cover this scenario: LH 0x11 and SW 0x12 -> err 1, rdata 0; a following LW 0x10 shows memory unchanged.
REQ-034 SHALL cover this scenario: LW 0x400 with DEPTH_WORDS = 256 -> err 1; load funct3 011 -> err 1.
REQ-035 SHALL cover this scenario: resp_ready held low 5 cycles -> resp_valid/rdata stable; req_valid high meanwhile -> no accept; after the resp handshake, the next accept occurs one edge later.
REQ-036 SHALL cover this scenario: with LATENCY = 3, SW 0x20 accepted, then reset_n pulsed low one cycle later -> resp_valid 0, LW 0x20 returns the prior contents.
